// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions.
// Holds the immediate-format encoding (also used by the immediate generator), the
// 7-bit major opcode constants, the decoded-entry record carried by decode_stage,
// and the occupancy states of the decode-stage skid buffer.
package riscv_pkg;

  localparam int unsigned Xlen = 32;

  // Immediate format select, consumed by the immediate generator.
  typedef enum logic [2:0] {
    ImmI = 3'b000,
    ImmS = 3'b001,
    ImmB = 3'b010,
    ImmU = 3'b011,
    ImmJ = 3'b100
  } imm_op_e;

  // Major opcodes, instr[6:0].
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;

  typedef struct packed {
    logic [Xlen-1:0] instr;
    logic [Xlen-1:0] pc;
    imm_op_e         imm_op;
    logic            uses_imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            illegal;
  } dec_entry_t;

  // Skid-buffer occupancy.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StTwo   = 2'b10
  } skid_state_e;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and issue-side handshake bundle of decode_stage.
// Fetch side : in_valid, in_ready, in_instr, in_pc.
// Issue side : out_valid, out_ready, out_instr, out_pc, out_imm_op, out_uses_imm,
//              out_rd, out_rs1, out_rs2, out_illegal.
// With DECODE_STALL_CNT_EN defined the bundle also carries stall_cnt.
// modport master: the environment (fetch unit + consumer); modport slave: the stage.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      out_imm_op;
  logic            out_uses_imm;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic            out_illegal;
`ifdef DECODE_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm_op, out_uses_imm,
    input  out_rd, out_rs1, out_rs2, out_illegal
`ifdef DECODE_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm_op, out_uses_imm,
    output out_rd, out_rs1, out_rs2, out_illegal
`ifdef DECODE_STALL_CNT_EN
    , output stall_cnt
`endif
  );

endinterface

// File: rtl/instr_classifier.sv
// Purely combinational opcode classifier.
// Ports:
//   i_opcode   - instr[6:0]
//   o_imm_op   - immediate format (I/S/B/U/J)
//   o_uses_imm - instruction consumes an immediate
//   o_illegal  - unsupported encoding (unknown opcode or instr[1:0] != 2'b11)
module instr_classifier
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  output imm_op_e    o_imm_op,
  output logic       o_uses_imm,
  output logic       o_illegal
);

  always_comb begin
    o_imm_op   = ImmI;
    o_uses_imm = 1'b0;
    o_illegal  = 1'b0;
    // Every legal opcode has instr[1:0] == 2'b11, so the full 7-bit compare covers it.
    case (i_opcode)
      OpcLoad, OpcOpImm, OpcJalr, OpcMiscMem, OpcSystem: begin
        o_imm_op   = ImmI;
        o_uses_imm = 1'b1;
      end
      OpcStore: begin
        o_imm_op   = ImmS;
        o_uses_imm = 1'b1;
      end
      OpcBranch: begin
        o_imm_op   = ImmB;
        o_uses_imm = 1'b1;
      end
      OpcLui, OpcAuipc: begin
        o_imm_op   = ImmU;
        o_uses_imm = 1'b1;
      end
      OpcJal: begin
        o_imm_op   = ImmJ;
        o_uses_imm = 1'b1;
      end
      OpcOp: begin
        o_imm_op   = ImmI;
        o_uses_imm = 1'b0;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// IF->ID decode stage with a 2-entry skid buffer.
// Accepts instructions over a valid/ready handshake, classifies the opcode and presents
// the decoded record one cycle after accept. in_ready depends only on registered state,
// so the stage sustains one instruction per cycle without a combinational ready path.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, discards all entries
//   flush  - discard held entries and any simultaneous accept (branch redirect)
//   dif    - decode_stage_if.slave: fetch-side in_* and issue-side out_* signals
// Build option: DECODE_STALL_CNT_EN adds dif.stall_cnt, a saturating count of cycles
// with out_valid=1 and out_ready=0, cleared by reset only.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  decode_stage_if.slave  dif
);

  skid_state_e r_state;
  skid_state_e w_state_next;
  dec_entry_t  r_main;   // drives the outputs
  dec_entry_t  r_skid;   // second-oldest entry
  dec_entry_t  w_dec;

  logic [XLEN-1:0] w_in_instr;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_accept;
  logic            w_drain;
  logic            w_load_main;
  logic            w_main_from_skid;
  logic            w_load_skid;
  imm_op_e         w_imm_op;
  logic            w_uses_imm;
  logic            w_illegal;

  assign w_in_instr  = dif.in_instr;
  assign w_in_ready  = (r_state != StTwo);
  assign w_out_valid = (r_state != StEmpty);
  assign w_accept    = dif.in_valid & w_in_ready;
  assign w_drain     = w_out_valid & dif.out_ready;

  instr_classifier u_classifier (
    .i_opcode   (w_in_instr[6:0]),
    .o_imm_op   (w_imm_op),
    .o_uses_imm (w_uses_imm),
    .o_illegal  (w_illegal)
  );

  always_comb begin
    w_dec          = '0;
    w_dec.instr    = w_in_instr;
    w_dec.pc       = dif.in_pc;
    w_dec.imm_op   = w_imm_op;
    w_dec.uses_imm = w_uses_imm;
    w_dec.rd       = w_in_instr[11:7];
    w_dec.rs1      = w_in_instr[19:15];
    w_dec.rs2      = w_in_instr[24:20];
    w_dec.illegal  = w_illegal;
  end

  always_comb begin
    w_state_next     = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      // Flush beats any simultaneous accept; the offered instruction is dropped.
      w_state_next = StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            w_state_next = StOne;
            w_load_main  = 1'b1;
          end
        end
        StOne: begin
          if (w_accept && w_drain) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_state_next = StTwo;
            w_load_skid  = 1'b1;
          end else if (w_drain) begin
            w_state_next = StEmpty;
          end
        end
        StTwo: begin
          // in_ready is low here, so only a drain can change occupancy.
          if (w_drain) begin
            w_state_next     = StOne;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_next = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_main) begin
        r_main <= w_dec;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign dif.in_ready     = w_in_ready;
  assign dif.out_valid    = w_out_valid;
  assign dif.out_instr    = r_main.instr;
  assign dif.out_pc       = r_main.pc;
  assign dif.out_imm_op   = r_main.imm_op;
  assign dif.out_uses_imm = r_main.uses_imm;
  assign dif.out_rd       = r_main.rd;
  assign dif.out_rs1      = r_main.rs1;
  assign dif.out_rs2      = r_main.rs2;
  assign dif.out_illegal  = r_main.illegal;

`ifdef DECODE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !dif.out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign dif.stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic clk;
  logic rst_n;
  logic flush;

  decode_stage_if #(.XLEN(32)) dif ();

  decode_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_pass;
  logic [31:0] got_q[$];

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  imm_op;
    logic        uses_imm;
    logic        illegal;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock; inputs are stable here, so log the output handshake first.
  task automatic step();
    if (dif.out_valid === 1'b1 && dif.out_ready === 1'b1) got_q.push_back(dif.out_instr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_seq[$];
    int          bad;
    n_total = 0;
    n_pass  = 0;

    vecs[0]  = '{32'h00510093, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd5};  // addi
    vecs[1]  = '{32'h00512423, 3'b001, 1'b1, 1'b0, 5'd8, 5'd2, 5'd5};  // sw
    vecs[2]  = '{32'h00208463, 3'b010, 1'b1, 1'b0, 5'd8, 5'd1, 5'd2};  // beq
    vecs[3]  = '{32'h12345037, 3'b011, 1'b1, 1'b0, 5'd0, 5'd8, 5'd3};  // lui
    vecs[4]  = '{32'h008000EF, 3'b100, 1'b1, 1'b0, 5'd1, 5'd0, 5'd8};  // jal
    vecs[5]  = '{32'h00000000, 3'b000, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0};  // all-zero
    vecs[6]  = '{32'h002081B3, 3'b000, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2};  // add
    vecs[7]  = '{32'h00000017, 3'b011, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0};  // auipc
    vecs[8]  = '{32'h00000073, 3'b000, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0};  // ecall
    vecs[9]  = '{32'h00008067, 3'b000, 1'b1, 1'b0, 5'd0, 5'd1, 5'd0};  // jalr
    vecs[10] = '{32'h0000A103, 3'b000, 1'b1, 1'b0, 5'd2, 5'd1, 5'd0};  // lw
    vecs[11] = '{32'h0000000F, 3'b000, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0};  // fence
    vecs[12] = '{32'h00000012, 3'b000, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0};  // instr[1:0]=10
    vecs[13] = '{32'h0000007F, 3'b000, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0};  // unknown opcode

    // Reset state.
    rst_n         = 1'b0;
    flush         = 1'b0;
    dif.in_valid  = 1'b0;
    dif.in_instr  = '0;
    dif.in_pc     = '0;
    dif.out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(dif.out_valid), 32'd0);
    check("rst_imm_op", 32'(dif.out_imm_op), 32'd0);
    check("rst_illegal", 32'(dif.out_illegal), 32'd0);
    check("rst_instr", dif.out_instr, 32'd0);
    check("rst_in_ready", 32'(dif.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(dif.in_ready), 32'd1);

    // Format decode table, one accept per vector with out_ready high.
    for (int i = 0; i < 14; i++) begin
      dif.out_ready = 1'b1;
      dif.in_valid  = 1'b1;
      dif.in_instr  = vecs[i].instr;
      dif.in_pc     = 32'h1000 + 32'(i) * 32'd4;
      step();
      dif.in_valid = 1'b0;
      check($sformatf("v%0d_out_valid", i), 32'(dif.out_valid), 32'd1);
      check($sformatf("v%0d_instr", i), dif.out_instr, vecs[i].instr);
      check($sformatf("v%0d_pc", i), dif.out_pc, 32'h1000 + 32'(i) * 32'd4);
      check($sformatf("v%0d_imm_op", i), 32'(dif.out_imm_op), 32'(vecs[i].imm_op));
      check($sformatf("v%0d_uses_imm", i), 32'(dif.out_uses_imm), 32'(vecs[i].uses_imm));
      check($sformatf("v%0d_illegal", i), 32'(dif.out_illegal), 32'(vecs[i].illegal));
      check($sformatf("v%0d_rd", i), 32'(dif.out_rd), 32'(vecs[i].rd));
      check($sformatf("v%0d_rs1", i), 32'(dif.out_rs1), 32'(vecs[i].rs1));
      check($sformatf("v%0d_rs2", i), 32'(dif.out_rs2), 32'(vecs[i].rs2));
      step();
      check($sformatf("v%0d_drained", i), 32'(dif.out_valid), 32'd0);
    end

    // Backpressure: three back-to-back offers with out_ready low.
    got_q.delete();
    dif.out_ready = 1'b0;
    dif.in_valid  = 1'b1;
    dif.in_instr  = 32'hA0000013;
    step();
    check("bp_ready_after_1", 32'(dif.in_ready), 32'd1);
    dif.in_instr = 32'hB0000013;
    step();
    check("bp_ready_full", 32'(dif.in_ready), 32'd0);
    check("bp_hold_first", dif.out_instr, 32'hA0000013);
    dif.in_instr = 32'hC0000013;
    step();
    step();
    check("bp_still_full", 32'(dif.in_ready), 32'd0);
    check("bp_still_first", dif.out_instr, 32'hA0000013);
    check("bp_valid", 32'(dif.out_valid), 32'd1);
    dif.out_ready = 1'b1;
    step();  // drain A, B moves to main
    check("bp_second", dif.out_instr, 32'hB0000013);
    check("bp_ready_back", 32'(dif.in_ready), 32'd1);
    step();  // accept C, drain B
    dif.in_valid = 1'b0;
    check("bp_third", dif.out_instr, 32'hC0000013);
    step();  // drain C
    check("bp_empty", 32'(dif.out_valid), 32'd0);
    exp_seq = '{32'hA0000013, 32'hB0000013, 32'hC0000013};
    check("bp_count", 32'(got_q.size()), 32'd3);
    bad = 0;
    for (int i = 0; i < 3; i++) if (i >= got_q.size() || got_q[i] !== exp_seq[i]) bad++;
    check("bp_order", 32'(bad), 32'd0);

    // Streaming: 100 cycles with both sides ready.
    got_q.delete();
    bad = 0;
    dif.out_ready = 1'b1;
    dif.in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      dif.in_instr = {12'(i), 20'h00013};
      if (dif.in_ready !== 1'b1) bad++;
      step();
    end
    dif.in_valid = 1'b0;
    step();
    step();
    check("stream_in_ready", 32'(bad), 32'd0);
    check("stream_count", 32'(got_q.size()), 32'd100);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i >= got_q.size() || got_q[i] !== {12'(i), 20'h00013}) bad++;
    end
    check("stream_order", 32'(bad), 32'd0);

    // Flush in TWO with an offered instruction.
    got_q.delete();
    dif.out_ready = 1'b0;
    dif.in_valid  = 1'b1;
    dif.in_instr  = 32'hD0000013;
    step();
    dif.in_instr = 32'hE0000013;
    step();
    check("fl_full", 32'(dif.in_ready), 32'd0);
    dif.in_instr = 32'hF0000013;
    flush        = 1'b1;
    step();
    flush        = 1'b0;
    dif.in_valid = 1'b0;
    check("fl_two_valid", 32'(dif.out_valid), 32'd0);
    check("fl_two_ready", 32'(dif.in_ready), 32'd1);
    // Flush in ONE while an accept is possible: the accept is discarded too.
    dif.in_valid = 1'b1;
    dif.in_instr = 32'h10000013;
    step();
    dif.in_instr = 32'h20000013;
    flush        = 1'b1;
    step();
    flush        = 1'b0;
    dif.in_valid = 1'b0;
    check("fl_one_valid", 32'(dif.out_valid), 32'd0);
    dif.out_ready = 1'b1;
    step();
    step();
    check("fl_nothing_out", 32'(got_q.size()), 32'd0);
    dif.in_valid = 1'b1;
    dif.in_instr = 32'h30000013;
    step();
    dif.in_valid = 1'b0;
    check("fl_resume", dif.out_instr, 32'h30000013);
    step();
    check("fl_resume_count", 32'(got_q.size()), 32'd1);

    // Asynchronous reset between edges while holding an entry.
    dif.out_ready = 1'b0;
    dif.in_valid  = 1'b1;
    dif.in_instr  = 32'h40000013;
    step();
    dif.in_valid = 1'b0;
    check("ar_before", 32'(dif.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid_now", 32'(dif.out_valid), 32'd0);
    check("ar_instr_now", dif.out_instr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("ar_ready", 32'(dif.in_ready), 32'd1);
    dif.out_ready = 1'b1;
    dif.in_valid  = 1'b1;
    dif.in_instr  = 32'h50000013;
    step();
    dif.in_valid = 1'b0;
    check("ar_first_valid", 32'(dif.out_valid), 32'd1);
    check("ar_first_instr", dif.out_instr, 32'h50000013);
    step();
    check("ar_drained", 32'(dif.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
